// File: rtl/ring_dec_if.sv
// Bundle of ring-counter sample bus and decoder results.
// The checker sees it through the slave modport and the ring side through the master modport.
interface ring_dec_if #(
   parameter int reg_size = 4,
   parameter int idx_w    = 2,
   parameter int rev_w    = 8
);
   logic [reg_size-1:0] q_in;
   logic [idx_w-1:0]    idx;
   logic                valid;
   logic                err;
   logic                err_flag;
   logic                wrap;
   logic [rev_w-1:0]    rev_cnt;

   modport master (output q_in, input idx, valid, err, err_flag, wrap, rev_cnt);
   modport slave  (input q_in, output idx, valid, err, err_flag, wrap, rev_cnt);
endinterface

// File: rtl/ring_dec.sv
// Receive-side checker/decoder for a one-hot ring counter: legality and step checks,
// binary index encoding, lock/fault tracking and revolution counting.
//
// state | meaning
// HUNT  | waiting for any legal one-hot code after reset or an illegal code
// CHECK | counting consecutive correct steps toward lock
// LOCK  | ring advancing correctly; idx is trustworthy
// FAULT | lock was lost; waiting for a legal code to restart checking
module ring_dec #(
   parameter int reg_size = 4,
   parameter int idx_w    = 2,
   parameter int lock_cnt = 2,
   parameter int rev_w    = 8
) (
   input logic       clk,
   input logic       clr,
   ring_dec_if.slave rb
);
   localparam int cnt_w = (lock_cnt < 2) ? 1 : $clog2(lock_cnt + 1);
   localparam logic [cnt_w-1:0] lock_m1 = cnt_w'(lock_cnt - 1);

   typedef enum logic [1:0] {HUNT, CHECK, LOCK, FAULT} state_t;

   state_t              state, state_nx;
   logic [cnt_w-1:0]    good_cnt, good_nx;
   logic [reg_size-1:0] prev, rot_prev;
   logic                legal, step_ok, err_nx, wrap_nx;
   logic [idx_w-1:0]    enc, idx_r;
   logic                valid_r, err_r, err_flag_r, wrap_r;
   logic [rev_w-1:0]    rev_r;

   always_comb begin
      legal    = $onehot(rb.q_in);
      rot_prev = {prev[reg_size-2:0], prev[reg_size-1]};
      step_ok  = legal && (rb.q_in == rot_prev);
      enc      = '0;
      for (int i = 0; i < reg_size; i++) begin
         if (rb.q_in[i]) enc = idx_w'(i);
      end
   end

   always_comb begin
      state_nx = state;
      good_nx  = good_cnt;
      err_nx   = 1'b0;
      wrap_nx  = 1'b0;
      case (state)
         HUNT: begin
            if (legal) begin
               state_nx = CHECK;
               good_nx  = '0;
            end
         end
         CHECK: begin
            if (step_ok) begin
               good_nx = good_cnt + cnt_w'(1);
               if (good_cnt == lock_m1) state_nx = LOCK;
            end else if (legal) begin
               good_nx = '0;
            end else begin
               state_nx = HUNT;
            end
         end
         LOCK: begin
            // a hold counts as a fault: the ring must advance every cycle
            if (step_ok) begin
               wrap_nx = rb.q_in[0];
            end else begin
               state_nx = FAULT;
               err_nx   = 1'b1;
            end
         end
         FAULT: begin
            if (legal) begin
               state_nx = CHECK;
               good_nx  = '0;
            end
         end
         default: state_nx = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= HUNT;
         good_cnt   <= '0;
         prev       <= '0;
         idx_r      <= '0;
         valid_r    <= 1'b0;
         err_r      <= 1'b0;
         err_flag_r <= 1'b0;
         wrap_r     <= 1'b0;
         rev_r      <= '0;
      end else begin
         state      <= state_nx;
         good_cnt   <= good_nx;
         prev       <= rb.q_in;
         if (legal) idx_r <= enc;
         valid_r    <= (state_nx == LOCK);
         err_r      <= err_nx;
         err_flag_r <= err_flag_r | err_nx;
         wrap_r     <= wrap_nx;
         if (wrap_nx) rev_r <= rev_r + rev_w'(1);
      end
   end

   assign rb.idx      = idx_r;
   assign rb.valid    = valid_r;
   assign rb.err      = err_r;
   assign rb.err_flag = err_flag_r;
   assign rb.wrap     = wrap_r;
   assign rb.rev_cnt  = rev_r;
endmodule
